// File: rtl/max2_log_pkg.sv
// Shared record type and widths for the second-largest change logger.
// Record fields are sized for the widest supported configuration.
package max2_log_pkg;
  localparam int DATA_W     = 32;
  localparam int TS_W       = 16;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [TS_W-1:0]   ts;
  } rec_t;
endpackage

// File: rtl/max2_log_fifo.sv
// Synchronous FIFO of rec_t records. A write appears at the head one cycle later.
// A push into a full FIFO is accepted only if a pop frees a slot in the same cycle.
module max2_log_fifo
  import max2_log_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  rec_t                     wr_rec,
  input  logic                     pop,
  output rec_t                     rd_rec,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  rec_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head is forced to zero when empty so stale storage never leaks out.
  assign rd_rec  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_rec;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/max2_change_logger.sv
// Logs {value, timestamp} whenever sample_in changes; record visible 1 cycle after detection.
// Sink stalls via out_ready; changes seen while full and not popping are dropped (MAX2_CHANGE_LOGGER_DROP_CNT_EN adds drop_count).
module max2_change_logger
  import max2_log_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TS_WIDTH   = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   sample_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_value,
  output logic [TS_WIDTH-1:0]     out_ts,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
`ifdef MAX2_CHANGE_LOGGER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]   drop_count
`endif
);
  logic [TS_WIDTH-1:0]   ts_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic                  push_req;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  drop;
  rec_t                  wr_rec;
  rec_t                  rd_rec;

  assign push_req  = (sample_in != prev_q);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign drop      = push_req && full && !pop;

  // DATA_WIDTH/TS_WIDTH must not exceed the package record field widths.
  always_comb begin
    wr_rec                     = '0;
    wr_rec.value[DATA_WIDTH-1:0] = sample_in;
    wr_rec.ts[TS_WIDTH-1:0]      = ts_q;
  end

  assign out_value = rd_rec.value[DATA_WIDTH-1:0];
  assign out_ts    = rd_rec.ts[TS_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ts_q   <= '0;
      prev_q <= '0;
    end else begin
      ts_q   <= ts_q + TS_WIDTH'(1);
      prev_q <= sample_in;
    end
  end

  max2_log_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_req),
    .wr_rec (wr_rec),
    .pop    (pop),
    .rd_rec (rd_rec),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

`ifdef MAX2_CHANGE_LOGGER_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end

  assign overflow = (drop_count != '0);
`else
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_max2_change_logger.sv
// Randomized + directed bench for max2_change_logger with a queue-based reference model
// and a negedge monitor that scoreboards every handshake.
module tb_max2_change_logger;
  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int TS_MOD = 1 << TW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_value;
  logic [TW-1:0] out_ts;
  logic [LW-1:0] level;
  logic          overflow;
`ifdef MAX2_CHANGE_LOGGER_DROP_CNT_EN
  logic [15:0]   drop_count;
`endif

  always #5 clk = ~clk;

  max2_change_logger #(
    .DATA_WIDTH (DW),
    .TS_WIDTH   (TW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sample_in  (sample_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_value  (out_value),
    .out_ts     (out_ts),
    .level      (level),
    .overflow   (overflow)
`ifdef MAX2_CHANGE_LOGGER_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  typedef struct {
    logic [DW-1:0] v;
    logic [TW-1:0] t;
  } rec_s;

  rec_s          model_q[$];   // what the FIFO should hold right now
  rec_s          exp_q[$];     // accepted records still to be seen on the output
  int unsigned   m_ts = 0;
  logic [DW-1:0] m_prev = '0;
  bit            m_ovf = 1'b0;
  int unsigned   m_drops = 0;
  bit            started = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO as a bounded queue, updated at each clock edge.
  always @(posedge clk) begin : model
    rec_s r;
    if (!resetn) begin
      model_q.delete();
      exp_q.delete();
      m_ts    = 0;
      m_prev  = '0;
      m_ovf   = 1'b0;
      m_drops = 0;
      started = 1'b1;
    end else begin
      if (model_q.size() != 0 && out_ready) void'(model_q.pop_front());
      if (sample_in != m_prev) begin
        r.v = sample_in;
        r.t = TW'(m_ts);
        if (model_q.size() < DEPTH) begin
          model_q.push_back(r);
          exp_q.push_back(r);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
      m_ts   = (m_ts + 1) % TS_MOD;
      m_prev = sample_in;
    end
  end

  always @(negedge clk) begin : monitor
    rec_s r;
    if (started) begin
      chk("out_valid", out_valid, model_q.size() != 0);
      chk("level", level, model_q.size());
      chk("overflow", overflow, m_ovf);
`ifdef MAX2_CHANGE_LOGGER_DROP_CNT_EN
      chk("drop_count", drop_count, m_drops);
`endif
      if (model_q.size() != 0) begin
        chk("head_value", out_value, model_q[0].v);
        chk("head_ts", out_ts, model_q[0].t);
      end else begin
        chk("idle_value", out_value, 0);
        chk("idle_ts", out_ts, 0);
      end
      if (resetn && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got value 0x%0h ts %0d, expected no record", out_value, out_ts);
        end else begin
          r = exp_q.pop_front();
          chk("pop_value", out_value, r.v);
          chk("pop_ts", out_ts, r.t);
        end
      end
    end
  end

  task automatic cyc(input logic [DW-1:0] s, input logic r);
    sample_in = s;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc('0, 1'b0);
    resetn = 1'b1;
  endtask

  initial begin : stim
    logic [DW-1:0] v;
    int thr;

    // Reset hold, then a constant zero input must never log anything.
    resetn = 1'b0;
    repeat (3) cyc('0, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) cyc('0, 1'($urandom_range(0, 1)));
    chk("quiet_valid", out_valid, 0);
    chk("quiet_level", level, 0);
    chk("quiet_overflow", overflow, 0);

    // Single change at cycle 3, visible at cycle 4.
    do_reset();
    for (int k = 0; k < 3; k++) cyc('0, 1'b1);
    cyc(32'd5, 1'b1);
    chk("first_valid", out_valid, 1);
    chk("first_value", out_value, 5);
    chk("first_ts", out_ts, 3);
    cyc(32'd5, 1'b1);
    chk("first_drained", level, 0);

    // Fill to DEPTH, then one drop.
    do_reset();
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    cyc(32'd7, 1'b0);
    cyc(32'd9, 1'b0);
    cyc(32'd11, 1'b0);
    cyc(32'd13, 1'b0);
    chk("full_level", level, 4);
    chk("full_no_ovf", overflow, 0);
    cyc(32'd15, 1'b0);
    chk("drop_ovf", overflow, 1);
    chk("drop_level", level, 4);
`ifdef MAX2_CHANGE_LOGGER_DROP_CNT_EN
    chk("drop_cnt_one", drop_count, 1);
`endif
    // Push and pop together while full.
    cyc(32'd17, 1'b1);
    chk("fullpp_level", level, 4);
    chk("fullpp_ovf", overflow, 1);
    for (int k = 0; k < 6; k++) cyc(32'd17, 1'b1);
    chk("drained_level", level, 0);

    // Stalled head must stay put while time advances.
    cyc(32'd21, 1'b0);
    for (int k = 0; k < 10; k++) cyc(32'd21, 1'b0);
    chk("stall_value", out_value, 21);
    cyc(32'd21, 1'b1);

    // Timestamp wrap with a 4-bit counter: cycle 17 records ts 1.
    do_reset();
    for (int k = 0; k < 17; k++) cyc('0, 1'b1);
    cyc(32'd3, 1'b0);
    chk("wrap_value", out_value, 3);
    chk("wrap_ts", out_ts, 1);

    // Reset with records stored discards them.
    cyc(32'd4, 1'b0);
    cyc(32'd6, 1'b0);
    chk("pre_rst_level", level, 3);
    do_reset();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_level", level, 0);
    chk("post_rst_ovf", overflow, 0);
    cyc('0, 1'b1);
    cyc('0, 1'b1);
    cyc(32'd8, 1'b1);
    chk("post_rst_ts", out_ts, 2);
    chk("post_rst_value", out_value, 8);

    // Random traffic with shifting sink pressure and occasional resets.
    thr = 50;
    v = '0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) thr = $urandom_range(0, 100);
      resetn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 19) == 0) v = $urandom;
        else v = DW'($urandom_range(0, 3));
      end
      cyc(v, 1'($urandom_range(0, 99) < thr));
    end
    resetn = 1'b1;
    for (int k = 0; k < 8; k++) cyc(v, 1'b1);
    chk("final_level", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/max2_change_logger.md
Name: max2_change_logger

Overview:
- Downstream consumer of the running second-largest tracker output.
- Every cycle it compares the incoming second-largest value with the previous one.
- On a change, it captures the new value and a cycle timestamp into a small FIFO.
- Records are drained through a valid/ready interface to a host/debug sink.

Parameters:
- DATA_WIDTH, 32, width of the tracked value (matches the upstream tracker).
- TS_WIDTH, 16, width of the free-running timestamp counter.
- DEPTH, 4, number of FIFO records; must be a power of 2, >= 2.

Ports:
- clk  input  1  clock.
- resetn  input  1  synchronous, active-low reset.
- sample_in  input  DATA_WIDTH  current second-largest value from upstream; valid every cycle.
- out_valid  output  1  head record available.
- out_ready  input  1  sink accepts the head record this cycle.
- out_value  output  DATA_WIDTH  value field of the head record.
- out_ts  output  TS_WIDTH  timestamp field of the head record.
- level  output  $clog2(DEPTH)+1  number of stored records.
- overflow  output  1  sticky flag: at least one record was dropped.

Behaviour:
- Reset: reset is resetn, synchronous, active-low; clock is clk. In the reset cycle ts, prev, read/write pointers, level and overflow all go to 0. out_valid=0; out_value/out_ts = 0.
- Timestamp: ts increments by 1 every non-reset cycle and wraps 2^TS_WIDTH-1 -> 0 silently.
  - First cycle after reset release samples ts=0.
- Change detect (combinational):
  - push_req = (sample_in != prev).
  - prev <= sample_in every non-reset cycle.
  - prev resets to 0, matching the upstream tracker's reset output, so no record is generated immediately after reset.
- Record = {sample_in, ts} as seen in the detection cycle.
- Latency: a change present at edge N is written at edge N. out_valid rises in cycle N+1 when the FIFO was empty (1-cycle latency; no bypass).
- Output handshake:
  - pop = out_valid && out_ready.
  - out_value/out_ts must be held stable while out_valid && !out_ready.
  - out_ready while empty is ignored.
- FIFO: pointer-based, log2(DEPTH)-bit pointers plus level counter.
  - full = (level==DEPTH); empty = (level==0).
- Simultaneous events:
  - push & pop, not full: both happen, level unchanged.
  - push & pop while full: pop frees a slot, push is accepted, level stays DEPTH, no overflow.
  - push while full, no pop: record dropped, overflow <= 1, FIFO contents untouched.
  - push & pop while empty: impossible, since out_valid=0 when empty.
- overflow clears only on reset.
- Reset mid-operation (resetn low for one cycle): all stored records are discarded. out_valid=0 in the following cycle regardless of out_ready.

Optional Feature:
- Macro: MAX2_CHANGE_LOGGER_DROP_CNT_EN.
- Defined: adds output drop_count [15:0].
  - Increments on every dropped record and saturates at 16'hFFFF.
  - Reset 0.
  - overflow = (drop_count != 0).
- Undefined: port absent; overflow is a plain sticky flop as above.

Decomposition:
- Package max2_log_pkg:
  - typedef struct packed rec_t {value, ts}, parameterised widths via package localparams DATA_W=32, TS_W=16.
  - localparam DROP_CNT_W=16.
- One sub-module: max2_log_fifo, a generic synchronous FIFO of rec_t with push/pop/full/empty/level.
- The top holds ts counter, prev register, change detect and overflow/drop logic.

Test Plan:
- Reset hold, then sample_in held at 0 for 20 cycles -> out_valid stays 0, level=0, overflow=0.
- Release reset (ts=0 at cycle 0); sample_in 0->5 at cycle 3; out_ready=1 -> out_valid=1 at cycle 4 with out_value=5, out_ts=3; level back to 0 at cycle 5.
- out_ready=0; sample_in changes at cycles 2,3,4,5 to 7,9,11,13 (DEPTH=4) -> level=4, overflow=0. Change to 15 at cycle 6 -> dropped, overflow=1, drop_count=1 (macro on). Draining yields (7,2),(9,3),(11,4),(13,5) in order.
- Full FIFO, out_ready=1 and a change in the same cycle -> level stays 4, overflow unchanged, new record appears last.
- out_ready=0 for 10 cycles with out_valid=1 -> out_value/out_ts constant; ts keeps counting. Force TS_WIDTH=4: change at cycle 17 records out_ts=1.
- Three records stored, resetn low one cycle -> next cycle out_valid=0, level=0, overflow=0, ts restarts at 0.
